cdb_result_queue: RTL and testbench
===================================

Name: cdb_result_queue

Overview:
- Per-execution-unit result buffer between an execution unit (ALU/MUL/MEM) and the fixed-priority CDB arbiter.
- Absorbs completed results while the arbiter grants the CDB to a higher-priority unit, so the unit never stalls on a lost grant.
- Presents the oldest result as a valid/tag/data triple and pops it on the arbiter's same-cycle ack.
- Supports pipeline flush and reports occupancy and head starvation.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- TAG_WIDTH, 6, ROB/physical tag width.
- DATA_WIDTH, 32, result data width.
- STARVE_LIMIT, 15, head-wait count at which starve is asserted; at most 255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  execution unit has a result this cycle.
- in_tag  input  TAG_WIDTH  result tag.
- in_data  input  DATA_WIDTH  result value.
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry present; connects to the arbiter's unitN_valid.
- out_tag  output  TAG_WIDTH  head tag.
- out_data  output  DATA_WIDTH  head data.
- out_ack  input  1  arbiter grant for this unit; combinational in the same cycle as out_valid.
- flush  input  1  synchronous discard of all entries (mispredict/exception).
- count  output  $clog2(DEPTH)+1  current occupancy.
- starve  output  1  head has waited at least STARVE_LIMIT cycles.

Behaviour:
- Circular buffer: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally; count is a separate register, 0..DEPTH.
- push = in_valid && in_ready. pop = out_valid && out_ack.
- in_ready = (count != DEPTH). This is registered state, with no combinational dependence on out_ack. When full and popping, no push is accepted that cycle.
- out_valid = (count != 0). out_tag/out_data are driven from mem[rd_ptr]. When empty, out_tag and out_data are 0.
- Latency: a push at edge N is visible on out_* after edge N (one cycle). Back-to-back pushes and pops sustain 1 entry/cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- out_ack while out_valid is low is ignored, with no pointer movement.
- in_valid while in_ready is low is dropped. The unit must hold the result; the queue never overwrites an entry.
- Head-wait counter, 8 bits:
  - Clears on pop, on flush, or when empty.
  - Otherwise increments while out_valid && !out_ack, saturating at 255.
  - starve = (wait_cnt >= STARVE_LIMIT), registered.
- flush:
  - Next edge sets count=0, rd_ptr=wr_ptr=0, wait_cnt=0.
  - Takes priority over a simultaneous push and pop; the push in a flush cycle is discarded.
- rst:
  - Same effect as flush, plus clears mem.
  - Output reset values: in_ready=1, out_valid=0, out_tag=0, out_data=0, count=0, starve=0.
  - Reset mid-operation discards all entries with no partial state.

Optional Feature:
- Macro CDB_RESULT_QUEUE_BYPASS_EN.
- Defined: when count==0 and in_valid, out_valid=1 and out_tag/out_data take in_tag/in_data combinationally (zero latency).
  - If out_ack is also asserted, the entry is consumed without being written, and count stays 0.
  - If out_ack is not asserted, the entry is written normally.
  - The bypass is suppressed during flush.
- Not defined: strict one-cycle latency with no input-to-output combinational path.

Decomposition:
- Shared package cdb_pkg holds:
  - TAG_WIDTH and DATA_WIDTH defaults.
  - typedef cdb_pkt_t {tag, data}.
  - CDB_STARVE_LIMIT_DEFAULT.
- The arbiter and reservation stations reuse cdb_pkt_t.
- One sub-module, cdb_queue_mem: DEPTH x cdb_pkt_t register array with one write port and one asynchronous read port, cleared on rst.

Test Plan:
- Fill and drain: push tags 1,2,3,4 with out_ack=0. Expect in_ready=0 and count=4. Then hold out_ack=1 for 4 cycles: out_tag sequence 1,2,3,4, then out_valid=0 and count=0.
- Full with pop: at count=4, assert in_valid (tag 9) and out_ack together. The push is rejected, count=3, and tag 9 is accepted on the next cycle. Order is preserved through pointer wrap.
- Streaming: push tag 5 (data 0xDEADBEEF) on one cycle and tag 6 on the next, with out_ack=1 every cycle. Each result appears on out_* exactly one cycle after its push, and count never exceeds 1.
- Starvation: one entry with out_ack held at 0. starve rises after 15 wait cycles; one ack clears starve and wait_cnt.
- Flush: count=3 with flush, in_valid and out_ack all asserted. Next cycle count=0, out_valid=0, and the pushed tag never appears.
- Bypass (macro defined): empty queue with in_valid (tag 7) and out_ack=1. Same-cycle out_valid=1 and out_tag=7, and count stays 0. Without the macro, out_valid=0 that cycle.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB types: result packet layout and default widths/limits used by
// the result queues, the CDB arbiter and the reservation stations.
package cdb_pkg;

  localparam int unsigned CDB_TAG_WIDTH            = 6;
  localparam int unsigned CDB_DATA_WIDTH           = 32;
  localparam int unsigned CDB_STARVE_LIMIT_DEFAULT = 15;
  localparam int unsigned CDB_WAIT_WIDTH           = 8;

  typedef struct packed {
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_queue_mem.sv
// DEPTH x cdb_pkt_t storage: one synchronous write port, one asynchronous
// read port, cleared on reset.
module cdb_queue_mem
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cdb_pkt_t      wdata,
  input  logic [AW-1:0] raddr,
  output cdb_pkt_t      rdata
);

  cdb_pkt_t mem_q [DEPTH];

  // Entry storage; reset wipes every slot so no stale result survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cdb_result_queue.sv
// Per-execution-unit result queue in front of the fixed-priority CDB arbiter.
// Buffers results while the unit loses arbitration, presents the oldest one
// and pops it on the same-cycle ack. Optional zero-latency bypass of an empty
// queue is enabled by defining CDB_RESULT_QUEUE_BYPASS_EN.
module cdb_result_queue
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TAG_WIDTH    = CDB_TAG_WIDTH,
  parameter int unsigned DATA_WIDTH   = CDB_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = CDB_STARVE_LIMIT_DEFAULT,
  localparam int unsigned PW          = $clog2(DEPTH),
  localparam int unsigned CW          = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output logic                  starve
);

  localparam int unsigned WW = CDB_WAIT_WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          ready_q;
  logic          valid_q;
  logic          starve_q;

  logic          push_c;
  logic          pop_c;
  logic          wr_en_c;
  logic          bypass_c;
  cdb_pkt_t      wr_pkt_c;
  cdb_pkt_t      rd_pkt_c;

  assign wr_pkt_c.tag  = CDB_TAG_WIDTH'(in_tag);
  assign wr_pkt_c.data = CDB_DATA_WIDTH'(in_data);

  cdb_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_c),
    .waddr (wr_ptr_q),
    .wdata (wr_pkt_c),
    .raddr (rd_ptr_q),
    .rdata (rd_pkt_c)
  );

  // Handshakes, pointer/occupancy update and head-wait counter next state.
  always_comb begin
    bypass_c = 1'b0;
`ifdef CDB_RESULT_QUEUE_BYPASS_EN
    bypass_c = !valid_q && in_valid && !flush;
`endif
    push_c   = in_valid && ready_q;
    pop_c    = valid_q && out_ack;
    // A bypassed result that is acked in the same cycle never touches storage.
    wr_en_c  = push_c && !flush && !(bypass_c && out_ack);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wait_d   = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)   rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_en_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (pop_c || !valid_q) begin
        wait_d = '0;
      end else if (wait_q != {WW{1'b1}}) begin
        wait_d = wait_q + WW'(1);
      end
    end
  end

  // State registers; ready/valid/starve are precomputed from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      ready_q  <= (count_d != CW'(DEPTH));
      valid_q  <= (count_d != '0);
      starve_q <= (wait_d >= WW'(STARVE_LIMIT));
    end
  end

  // Head presentation; zeroed when empty, optionally bypassed from the input.
  always_comb begin
    out_valid = valid_q;
    out_tag   = valid_q ? TAG_WIDTH'(rd_pkt_c.tag) : '0;
    out_data  = valid_q ? DATA_WIDTH'(rd_pkt_c.data) : '0;
    if (bypass_c) begin
      out_valid = 1'b1;
      out_tag   = in_tag;
      out_data  = in_data;
    end
  end

  assign in_ready = ready_q;
  assign count    = count_q;
  assign starve   = starve_q;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Directed bench for cdb_result_queue: vector table plus hand sequences for
// starvation, mid-operation reset and the empty-queue bypass case.
module tb_cdb_result_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_tag;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [5:0]  out_tag;
  logic [31:0] out_data;
  logic        out_ack;
  logic        flush;
  logic [2:0]  count;
  logic        starve;

  int checks   = 0;
  int failures = 0;

  cdb_result_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .flush     (flush),
    .count     (count),
    .starve    (starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [5:0]  tag;
    logic [31:0] data;
    logic        ack;
    logic        fl;
    logic        e_valid;
    logic [5:0]  e_tag;
    logic [31:0] e_data;
    logic [2:0]  e_count;
    logic        e_ready;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [31:0] dval(input logic [5:0] t);
    return 32'hA000_0000 | {26'h0, t};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [5:0] tag,
                              input logic ack, input logic fl,
                              input logic ev, input logic [5:0] et,
                              input logic [2:0] ec, input logic er);
    vec_t v;
    v.iv      = iv;
    v.tag     = tag;
    v.data    = iv ? dval(tag) : 32'h0;
    v.ack     = ack;
    v.fl      = fl;
    v.e_valid = ev;
    v.e_tag   = et;
    v.e_data  = ev ? dval(et) : 32'h0;
    v.e_count = ec;
    v.e_ready = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_tag   = '0;
    in_data  = '0;
    out_ack  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [5:0] tag, input logic ack);
    in_valid = iv;
    in_tag   = tag;
    in_data  = dval(tag);
    out_ack  = ack;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);

    // Fill, full-with-pop, drain through wrap
    vecs[0]  = mk(1, 6'd1, 0, 0, 1, 6'd1, 3'd1, 1);
    vecs[1]  = mk(1, 6'd2, 0, 0, 1, 6'd1, 3'd2, 1);
    vecs[2]  = mk(1, 6'd3, 0, 0, 1, 6'd1, 3'd3, 1);
    vecs[3]  = mk(1, 6'd4, 0, 0, 1, 6'd1, 3'd4, 0);
    vecs[4]  = mk(1, 6'd9, 1, 0, 1, 6'd2, 3'd3, 1);
    vecs[5]  = mk(1, 6'd9, 0, 0, 1, 6'd2, 3'd4, 0);
    vecs[6]  = mk(0, 6'd0, 1, 0, 1, 6'd3, 3'd3, 1);
    vecs[7]  = mk(0, 6'd0, 1, 0, 1, 6'd4, 3'd2, 1);
    vecs[8]  = mk(0, 6'd0, 1, 0, 1, 6'd9, 3'd1, 1);
    vecs[9]  = mk(0, 6'd0, 1, 0, 0, 6'd0, 3'd0, 1);
    vecs[10] = mk(0, 6'd0, 1, 0, 0, 6'd0, 3'd0, 1);
    // Streaming with ack held every cycle
`ifdef CDB_RESULT_QUEUE_BYPASS_EN
    vecs[11] = mk(1, 6'd5, 1, 0, 0, 6'd0, 3'd0, 1);
    vecs[12] = mk(1, 6'd6, 1, 0, 0, 6'd0, 3'd0, 1);
`else
    vecs[11] = mk(1, 6'd5, 1, 0, 1, 6'd5, 3'd1, 1);
    vecs[12] = mk(1, 6'd6, 1, 0, 1, 6'd6, 3'd1, 1);
`endif
    vecs[11].data = 32'hDEAD_BEEF;
    if (vecs[11].e_valid) vecs[11].e_data = 32'hDEAD_BEEF;
    vecs[13] = mk(0, 6'd0, 1, 0, 0, 6'd0, 3'd0, 1);
    // Flush with simultaneous push and pop
    vecs[14] = mk(1, 6'h11, 0, 0, 1, 6'h11, 3'd1, 1);
    vecs[15] = mk(1, 6'h12, 0, 0, 1, 6'h11, 3'd2, 1);
    vecs[16] = mk(1, 6'h13, 0, 0, 1, 6'h11, 3'd3, 1);
    vecs[17] = mk(1, 6'h3F, 1, 1, 0, 6'h00, 3'd0, 1);
    vecs[18] = mk(1, 6'h20, 0, 0, 1, 6'h20, 3'd1, 1);
    vecs[19] = mk(0, 6'd0, 1, 0, 0, 6'd0, 3'd0, 1);

    for (int i = 0; i < 20; i++) begin
      in_valid = vecs[i].iv;
      in_tag   = vecs[i].tag;
      in_data  = vecs[i].data;
      out_ack  = vecs[i].ack;
      flush    = vecs[i].fl;
      @(posedge clk);
      #1;
      idle();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_out_tag", i), 32'(out_tag), 32'(vecs[i].e_tag));
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_starve", i), 32'(starve), 32'd0);
    end

    // Starvation: head waits unacked until the limit, then one ack clears it
    step(1, 6'h2A, 0);
    repeat (14) @(posedge clk);
    #1;
    chk("starve_before_limit", 32'(starve), 32'd0);
    chk("starve_head_count", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    chk("starve_at_limit", 32'(starve), 32'd1);
    chk("starve_head_tag", 32'(out_tag), 32'h2A);
    step(0, 6'd0, 1);
    chk("starve_cleared", 32'(starve), 32'd0);
    chk("starve_drained", 32'(count), 32'd0);
    // Wait counter must restart from zero for the next head
    step(1, 6'h2B, 0);
    repeat (14) @(posedge clk);
    #1;
    chk("starve_restart", 32'(starve), 32'd0);
    step(0, 6'd0, 1);

    // Reset in the middle of operation
    step(1, 6'h31, 0);
    step(1, 6'h32, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    step(1, 6'h33, 0);
    chk("midrst_new_head", 32'(out_tag), 32'h33);
    chk("midrst_new_count", 32'(count), 32'd1);
    step(0, 6'd0, 1);

    // Empty queue, result and ack in the same cycle
    in_valid = 1'b1;
    in_tag   = 6'd7;
    in_data  = dval(6'd7);
    out_ack  = 1'b1;
    #1;
`ifdef CDB_RESULT_QUEUE_BYPASS_EN
    chk("byp_same_cycle_valid", 32'(out_valid), 32'd1);
    chk("byp_same_cycle_tag", 32'(out_tag), 32'd7);
    @(posedge clk);
    #1;
    idle();
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_out_valid", 32'(out_valid), 32'd0);
`else
    chk("byp_same_cycle_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    idle();
    chk("byp_count", 32'(count), 32'd1);
    chk("byp_out_tag", 32'(out_tag), 32'd7);
    step(0, 6'd0, 1);
    chk("byp_drained", 32'(count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
